// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the Mini SRC datapath: fetch plus per-opcode execute steps.
// Latency: one step per clock, 4..8 cycles per instruction including the 3-cycle fetch; no wait states.
// No backpressure: the datapath accepts every strobe in the cycle it is asserted.
//
// Ports:
//   clk, clr        rising-edge clock; asynchronous active-low reset (forces RST, all outputs 0)
//   opcode          IR[31:27] from the datapath, captured on the T2->T3 edge
//   CON_out         branch condition, only consulted in branch step T6
//   stop            halt request, only sampled on edges that would enter T0
//   run             high in T0..T7
//   remaining outputs are datapath register selects, loads, bus drivers and MDR input select
module control_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       CON_out,
  input  logic       stop,
  output logic       run,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       R_enable,
  output logic       Rout,
  output logic       BAout,
  output logic [2:0] MDR_read,
  output logic       RAM_write,
  output logic       IncPC,
  output logic       CON_enable,
  output logic       MDR_enable,
  output logic       MAR_enable,
  output logic       HI_enable,
  output logic       LO_enable,
  output logic       Z_enable,
  output logic       Y_enable,
  output logic       PC_enable,
  output logic       IR_enable,
  output logic       InPort_enable,
  output logic       OutPort_enable,
  output logic       MDRout,
  output logic       PCout,
  output logic       Yout,
  output logic       ZLowout,
  output logic       ZHighout,
  output logic       LOout,
  output logic       HIout,
  output logic       Cout,
  output logic       InPortout
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] last_step;
  logic [4:0] op_q;

  // Opcode classes; anything not matched below behaves as nop.
  logic is_ld, is_ldi, is_st, is_alu3, is_imm, is_mul, is_un;
  logic is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt;

  assign is_ld   = (op_q == 5'd0);
  assign is_ldi  = (op_q == 5'd1);
  assign is_st   = (op_q == 5'd2);
  assign is_alu3 = (op_q >= 5'd3)  && (op_q <= 5'd10);
  assign is_imm  = (op_q >= 5'd11) && (op_q <= 5'd13);
  assign is_mul  = (op_q == 5'd14) || (op_q == 5'd15);
  assign is_un   = (op_q == 5'd16) || (op_q == 5'd17);
  assign is_br   = (op_q == 5'd18);
  assign is_jr   = (op_q == 5'd19);
  assign is_jal  = (op_q == 5'd20);
  assign is_in   = (op_q == 5'd21);
  assign is_out  = (op_q == 5'd22);
  assign is_mfhi = (op_q == 5'd23);
  assign is_mflo = (op_q == 5'd24);
  assign is_halt = (op_q == 5'd26);

  // Final execute step of the latched instruction.
  always_comb begin
    if (is_ld || is_st)                 last_step = S_T7;
    else if (is_mul || is_br)           last_step = S_T6;
    else if (is_alu3 || is_imm || is_ldi) last_step = S_T5;
    else if (is_un || is_jal || is_in)  last_step = S_T4;
    else                                last_step = S_T3;
  end

  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:  state_nxt = stop ? S_HALT : S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if ((state == S_T3) && is_halt) state_nxt = S_HALT;
        else if (state == last_step)    state_nxt = stop ? S_HALT : S_T0;
        else                            state_nxt = state + 4'd1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_RST;
      op_q  <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) op_q <= opcode;
    end
  end

  // Moore decode of state and latched opcode; only branch T6 also looks at CON_out.
  // RST and HALT fall through to the all-zero defaults.
  always_comb begin
    run = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; R_enable = 1'b0; Rout = 1'b0; BAout = 1'b0;
    MDR_read = 3'b000; RAM_write = 1'b0; IncPC = 1'b0; CON_enable = 1'b0;
    MDR_enable = 1'b0; MAR_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0; Z_enable = 1'b0;
    Y_enable = 1'b0; PC_enable = 1'b0; IR_enable = 1'b0; InPort_enable = 1'b0; OutPort_enable = 1'b0;
    MDRout = 1'b0; PCout = 1'b0; Yout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
    LOout = 1'b0; HIout = 1'b0; Cout = 1'b0; InPortout = 1'b0;
    case (state)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; Z_enable = 1'b1;
      end
      S_T1: begin
        run = 1'b1; ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 3'b010; MDR_enable = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IR_enable = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_alu3 || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
        end else if (is_un) begin
          Grb = 1'b1; Rout = 1'b1; Z_enable = 1'b1;
        end else if (is_mul) begin
          Gra = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CON_enable = 1'b1;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
        end else if (is_jal) begin
          PCout = 1'b1; Grb = 1'b1; R_enable = 1'b1;   // link register sits in the rb field
        end else if (is_in) begin
          InPort_enable = 1'b1;
        end else if (is_out) begin
          Gra = 1'b1; Rout = 1'b1; OutPort_enable = 1'b1;
        end else if (is_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end else if (is_mflo) begin
          LOout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_alu3) begin
          Grc = 1'b1; Rout = 1'b1; Z_enable = 1'b1;
        end else if (is_imm || is_ld || is_ldi || is_st) begin
          Cout = 1'b1; Z_enable = 1'b1;
        end else if (is_un) begin
          ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end else if (is_mul) begin
          Grb = 1'b1; Rout = 1'b1; Z_enable = 1'b1;
        end else if (is_br) begin
          PCout = 1'b1; Y_enable = 1'b1;
        end else if (is_jal) begin
          Gra = 1'b1; Rout = 1'b1; PC_enable = 1'b1;
        end else if (is_in) begin
          InPortout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end
      end
      S_T5: begin
        run = 1'b1;
        if (is_alu3 || is_imm || is_ldi) begin
          ZLowout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end else if (is_mul) begin
          ZLowout = 1'b1; LO_enable = 1'b1;
        end else if (is_ld || is_st) begin
          ZLowout = 1'b1; MAR_enable = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Z_enable = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (is_mul) begin
          ZHighout = 1'b1; HI_enable = 1'b1;
        end else if (is_ld) begin
          MDR_read = 3'b010; MDR_enable = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDR_read = 3'b001; MDR_enable = 1'b1;
        end else if (is_br && CON_out) begin
          ZLowout = 1'b1; PC_enable = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; R_enable = 1'b1;
        end else if (is_st) begin
          RAM_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a step-counting instruction model predicts every output each cycle,
// with directed sequences pinning reset, add, ld/st, br, halt, stop and mid-instruction clr,
// followed by randomized opcode/CON_out/stop/clr traffic.
`timescale 1ns/1ps
module tb_control_unit;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic CON_out = 1'b0;
  logic stop = 1'b0;

  logic run, Gra, Grb, Grc, R_enable, Rout, BAout;
  logic [2:0] MDR_read;
  logic RAM_write, IncPC, CON_enable, MDR_enable, MAR_enable, HI_enable, LO_enable, Z_enable;
  logic Y_enable, PC_enable, IR_enable, InPort_enable, OutPort_enable;
  logic MDRout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, InPortout;

  control_unit dut (
    .clk(clk), .clr(clr), .opcode(opcode), .CON_out(CON_out), .stop(stop),
    .run(run), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_enable(R_enable), .Rout(Rout), .BAout(BAout),
    .MDR_read(MDR_read), .RAM_write(RAM_write), .IncPC(IncPC), .CON_enable(CON_enable),
    .MDR_enable(MDR_enable), .MAR_enable(MAR_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .Z_enable(Z_enable), .Y_enable(Y_enable), .PC_enable(PC_enable), .IR_enable(IR_enable),
    .InPort_enable(InPort_enable), .OutPort_enable(OutPort_enable), .MDRout(MDRout), .PCout(PCout),
    .Yout(Yout), .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
    .Cout(Cout), .InPortout(InPortout)
  );

  always #5 clk = ~clk;

  // All outputs packed into one word; bit positions below.
  logic [31:0] dut_v;
  assign dut_v = {run, Gra, Grb, Grc, R_enable, Rout, BAout, MDR_read, RAM_write, IncPC, CON_enable,
                  MDR_enable, MAR_enable, HI_enable, LO_enable, Z_enable, Y_enable, PC_enable,
                  IR_enable, InPort_enable, OutPort_enable, MDRout, PCout, Yout, ZLowout, ZHighout,
                  LOout, HIout, Cout, InPortout};

  localparam logic [31:0] B_RUN = 32'h1 << 31, B_GRA = 32'h1 << 30, B_GRB = 32'h1 << 29;
  localparam logic [31:0] B_GRC = 32'h1 << 28, B_REN = 32'h1 << 27, B_ROUT = 32'h1 << 26;
  localparam logic [31:0] B_BA = 32'h1 << 25, B_MDATA = 32'h1 << 24, B_MRAM = 32'h1 << 23;
  localparam logic [31:0] B_MBUS = 32'h1 << 22, B_RAMW = 32'h1 << 21, B_INCPC = 32'h1 << 20;
  localparam logic [31:0] B_CONEN = 32'h1 << 19, B_MDREN = 32'h1 << 18, B_MAREN = 32'h1 << 17;
  localparam logic [31:0] B_HIEN = 32'h1 << 16, B_LOEN = 32'h1 << 15, B_ZEN = 32'h1 << 14;
  localparam logic [31:0] B_YEN = 32'h1 << 13, B_PCEN = 32'h1 << 12, B_IREN = 32'h1 << 11;
  localparam logic [31:0] B_INEN = 32'h1 << 10, B_OUTEN = 32'h1 << 9, B_MDROUT = 32'h1 << 8;
  localparam logic [31:0] B_PCOUT = 32'h1 << 7, B_YOUT = 32'h1 << 6, B_ZLO = 32'h1 << 5;
  localparam logic [31:0] B_ZHI = 32'h1 << 4, B_LOOUT = 32'h1 << 3, B_HIOUT = 32'h1 << 2;
  localparam logic [31:0] B_COUT = 32'h1 << 1, B_INOUT = 32'h1 << 0;

  localparam logic [31:0] T0V = B_RUN | B_PCOUT | B_MAREN | B_INCPC | B_ZEN;

  // Instruction classes used by the model.
  localparam int C_NOP = 0, C_ALU3 = 1, C_IMM = 2, C_UN = 3, C_MUL = 4, C_LDI = 5, C_LD = 6;
  localparam int C_ST = 7, C_BR = 8, C_JR = 9, C_JAL = 10, C_IN = 11, C_OUT = 12, C_MFHI = 13;
  localparam int C_MFLO = 14, C_HALT = 15;

  function automatic int op_class(input logic [4:0] op);
    case (op) inside
      5'd0:            return C_LD;
      5'd1:            return C_LDI;
      5'd2:            return C_ST;
      [5'd3:5'd10]:    return C_ALU3;
      [5'd11:5'd13]:   return C_IMM;
      5'd14, 5'd15:    return C_MUL;
      5'd16, 5'd17:    return C_UN;
      5'd18:           return C_BR;
      5'd19:           return C_JR;
      5'd20:           return C_JAL;
      5'd21:           return C_IN;
      5'd22:           return C_OUT;
      5'd23:           return C_MFHI;
      5'd24:           return C_MFLO;
      5'd26:           return C_HALT;
      default:         return C_NOP;
    endcase
  endfunction

  // Model tables: fetch steps, execute steps (index 0 = T3) and total cycles per class.
  logic [31:0] fetch_tbl [0:2];
  logic [31:0] exec_tbl [0:15][0:4];
  int          len_tbl  [0:15];

  localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;
  int         m_mode = M_RST;
  int         m_step = 0;
  logic [4:0] m_op   = 5'd0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode <= M_RST;
      m_step <= 0;
    end else if (m_mode == M_RST) begin
      m_mode <= stop ? M_HALT : M_RUN;
      m_step <= 0;
    end else if (m_mode == M_RUN) begin
      if (m_step == 2) m_op <= opcode;
      if (m_step == 3 && op_class(m_op) == C_HALT) begin
        m_mode <= M_HALT;
      end else if (m_step == len_tbl[op_class(m_op)] - 1) begin
        m_mode <= stop ? M_HALT : M_RUN;
        m_step <= 0;
      end else begin
        m_step <= m_step + 1;
      end
    end
  end

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    int c;
    if (m_mode != M_RUN) return 32'h0;
    v = B_RUN;
    if (m_step < 3) begin
      v |= fetch_tbl[m_step];
    end else begin
      c = op_class(m_op);
      v |= exec_tbl[c][m_step - 3];
      if (c == C_BR && m_step == 6 && CON_out) v |= B_ZLO | B_PCEN;
    end
    return v;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] snap [0:7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: dut=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From T0: run one instruction of ncyc cycles, snapshot each cycle, confirm return to T0.
  task automatic instr(input string nm, input logic [4:0] op, input logic con, input int ncyc);
    opcode  = op;
    CON_out = con;
    snap[0] = dut_v;
    for (int c = 1; c < ncyc; c++) begin
      tick();
      snap[c] = dut_v;
    end
    tick();
    chk({nm, "_back_to_t0"}, dut_v, T0V);
  endtask

  // Mid-cycle clr pulse spanning one rising edge, then refetch.
  task automatic reset_seq(input string nm);
    #2 clr = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    tick();
    chk({nm, "_refetch"}, dut_v, T0V);
  endtask

  initial begin
    fetch_tbl[0] = B_PCOUT | B_MAREN | B_INCPC | B_ZEN;
    fetch_tbl[1] = B_ZLO | B_PCEN | B_MRAM | B_MDREN;
    fetch_tbl[2] = B_MDROUT | B_IREN;
    for (int c = 0; c < 16; c++)
      for (int k = 0; k < 5; k++) exec_tbl[c][k] = 32'h0;
    exec_tbl[C_ALU3][0] = B_GRB | B_ROUT | B_YEN;
    exec_tbl[C_ALU3][1] = B_GRC | B_ROUT | B_ZEN;
    exec_tbl[C_ALU3][2] = B_ZLO | B_GRA | B_REN;
    exec_tbl[C_IMM][0]  = B_GRB | B_ROUT | B_YEN;
    exec_tbl[C_IMM][1]  = B_COUT | B_ZEN;
    exec_tbl[C_IMM][2]  = B_ZLO | B_GRA | B_REN;
    exec_tbl[C_UN][0]   = B_GRB | B_ROUT | B_ZEN;
    exec_tbl[C_UN][1]   = B_ZLO | B_GRA | B_REN;
    exec_tbl[C_MUL][0]  = B_GRA | B_ROUT | B_YEN;
    exec_tbl[C_MUL][1]  = B_GRB | B_ROUT | B_ZEN;
    exec_tbl[C_MUL][2]  = B_ZLO | B_LOEN;
    exec_tbl[C_MUL][3]  = B_ZHI | B_HIEN;
    exec_tbl[C_LDI][0]  = B_GRB | B_ROUT | B_BA | B_YEN;
    exec_tbl[C_LDI][1]  = B_COUT | B_ZEN;
    exec_tbl[C_LDI][2]  = B_ZLO | B_GRA | B_REN;
    exec_tbl[C_LD]      = '{B_GRB | B_ROUT | B_BA | B_YEN, B_COUT | B_ZEN, B_ZLO | B_MAREN,
                            B_MRAM | B_MDREN, B_MDROUT | B_GRA | B_REN};
    exec_tbl[C_ST]      = '{B_GRB | B_ROUT | B_BA | B_YEN, B_COUT | B_ZEN, B_ZLO | B_MAREN,
                            B_GRA | B_ROUT | B_MBUS | B_MDREN, B_RAMW};
    exec_tbl[C_BR][0]   = B_GRA | B_ROUT | B_CONEN;
    exec_tbl[C_BR][1]   = B_PCOUT | B_YEN;
    exec_tbl[C_BR][2]   = B_COUT | B_ZEN;
    exec_tbl[C_JR][0]   = B_GRA | B_ROUT | B_PCEN;
    exec_tbl[C_JAL][0]  = B_PCOUT | B_GRB | B_REN;
    exec_tbl[C_JAL][1]  = B_GRA | B_ROUT | B_PCEN;
    exec_tbl[C_IN][0]   = B_INEN;
    exec_tbl[C_IN][1]   = B_INOUT | B_GRA | B_REN;
    exec_tbl[C_OUT][0]  = B_GRA | B_ROUT | B_OUTEN;
    exec_tbl[C_MFHI][0] = B_HIOUT | B_GRA | B_REN;
    exec_tbl[C_MFLO][0] = B_LOOUT | B_GRA | B_REN;
    len_tbl = '{4, 6, 6, 5, 7, 6, 8, 8, 7, 4, 5, 5, 4, 4, 4, 4};

    // Per-cycle comparison against the model, plus the single-bus-driver rule.
    fork
      forever begin
        @(negedge clk);
        chk("cycle", dut_v, model_vec());
        chk("bus_drivers", {31'b0, ($countones(dut_v[8:0]) > 1)}, 32'h0);
      end
    join_none

    #2 clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", dut_v, 32'h0);
    clr = 1'b1;
    tick();
    chk("first_t0", dut_v, T0V);

    instr("add", 5'd3, 1'b0, 6);
    chk("add_t3", snap[3], B_RUN | B_GRB | B_ROUT | B_YEN);
    chk("add_t4", snap[4], B_RUN | B_GRC | B_ROUT | B_ZEN);
    chk("add_t5", snap[5], B_RUN | B_ZLO | B_GRA | B_REN);

    instr("ld", 5'd0, 1'b0, 8);
    chk("ld_t6", snap[6], B_RUN | B_MRAM | B_MDREN);
    chk("ld_t7", snap[7], B_RUN | B_MDROUT | B_GRA | B_REN);

    instr("st", 5'd2, 1'b0, 8);
    chk("st_t6", snap[6], B_RUN | B_GRA | B_ROUT | B_MBUS | B_MDREN);
    chk("st_t7", snap[7], B_RUN | B_RAMW);

    instr("br_taken", 5'd18, 1'b1, 7);
    chk("br_taken_t6", snap[6], B_RUN | B_ZLO | B_PCEN);
    instr("br_not_taken", 5'd18, 1'b0, 7);
    chk("br_not_taken_t6", snap[6], B_RUN);

    instr("jal", 5'd20, 1'b0, 5);
    chk("jal_t3", snap[3], B_RUN | B_PCOUT | B_GRB | B_REN);
    instr("undef_nop", 5'd30, 1'b0, 4);
    chk("undef_t3", snap[3], B_RUN);

    // halt: T3 still running, then everything silent
    opcode = 5'd26;
    repeat (3) tick();
    chk("halt_t3", dut_v, B_RUN);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_idle", dut_v, 32'h0);
    end
    reset_seq("halt");

    // stop during add: instruction completes, then HALT instead of T0
    opcode = 5'd3;
    tick();
    stop = 1'b1;
    repeat (4) tick();
    chk("stop_add_t5", dut_v, B_RUN | B_ZLO | B_GRA | B_REN);
    tick();
    chk("stop_halt", dut_v, 32'h0);
    stop = 1'b0;
    reset_seq("stop");

    // clr during mul T5: outputs drop at once, HI_enable never pulses
    opcode = 5'd14;
    repeat (5) tick();
    chk("mul_t5", dut_v, B_RUN | B_ZLO | B_LOEN);
    #2 clr = 1'b0;
    #1;
    chk("mul_clr_async", dut_v, 32'h0);
    @(posedge clk);
    #1;
    chk("mul_no_hi", dut_v, 32'h0);
    clr = 1'b1;
    tick();
    chk("mul_refetch", dut_v, T0V);

    // Random traffic; model tracks everything, halts recovered with clr.
    for (int i = 0; i < 3000; i++) begin
      tick();
      opcode  = 5'($urandom);
      CON_out = 1'($urandom);
      stop    = ($urandom_range(0, 39) == 0);
      if (m_mode == M_HALT || $urandom_range(0, 149) == 0) begin
        #2 clr = 1'b0;
        @(posedge clk);
        #1 clr = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle hardwired controller for the Mini SRC processor: the driving end of the datapath control interface. Sequences fetch and per-opcode execute steps, and asserts the datapath's register-enable, bus-out, MDR-select, RAM-write, IncPC, CON and Gra/Grb/Grc strobes each clock. It consumes the decoded `opcode` and the `CON_out` branch flag back from the datapath, and instantiates beside `Datapath` in the CPU top.

## Interface
- No parameters.
- clk  in  1  rising-edge clock, shared with datapath
- clr  in  1  asynchronous, active-low reset
- opcode  in  5  IR[31:27] from datapath
- CON_out  in  1  branch-condition flag from datapath
- stop  in  1  halt request, sampled only at entry to T0
- run  out  1  high while fetching/executing
- Gra, Grb, Grc, R_enable, Rout, BAout  out  1 each  register-file selects
- MDR_read  out  3  one-hot MDR input select: 001 bus, 010 RAM, 100 Mdatain; 000 idle
- RAM_write, IncPC, CON_enable  out  1 each
- MDR_enable, MAR_enable, HI_enable, LO_enable, Z_enable, Y_enable, PC_enable, IR_enable, InPort_enable, OutPort_enable  out  1 each  register loads
- MDRout, PCout, Yout, ZLowout, ZHighout, LOout, HIout, Cout, InPortout  out  1 each  bus drivers
- `Yout` and `Mdatain` select are never used by this block; both tie to 0.

## Operation
- States: RST, T0, T1, T2, T3..T7 (execute steps), HALT. Outputs are Moore decodes of state and latched opcode, except branch T6 (also `CON_out`).
- Opcode encoding: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Undefined encodings execute as nop.
- Fetch: T0 PCout, MAR_enable, IncPC, Z_enable. T1 ZLowout, PC_enable, MDR_read=010, MDR_enable. T2 MDRout, IR_enable. Opcode is latched on the T2→T3 edge and held for the instruction.
- ALU 3-reg (add..or): T3 Grb Rout Y_enable; T4 Grc Rout Z_enable; T5 ZLowout Gra R_enable.
- addi/andi/ori: T3 Grb Rout Y_enable; T4 Cout Z_enable; T5 ZLowout Gra R_enable.
- neg/not: T3 Grb Rout Z_enable; T4 ZLowout Gra R_enable.
- mul/div: T3 Gra Rout Y_enable; T4 Grb Rout Z_enable; T5 ZLowout LO_enable; T6 ZHighout HI_enable.
- ld/st/ldi common: T3 Grb Rout BAout Y_enable; T4 Cout Z_enable.
  - ldi: T5 ZLowout Gra R_enable.
  - ld: T5 ZLowout MAR_enable; T6 MDR_read=010 MDR_enable; T7 MDRout Gra R_enable.
  - st: T5 ZLowout MAR_enable; T6 Gra Rout MDR_read=001 MDR_enable; T7 RAM_write.
- br: T3 Gra Rout CON_enable; T4 PCout Y_enable; T5 Cout Z_enable; T6 ZLowout and PC_enable only if `CON_out`=1.
- jr: T3 Gra Rout PC_enable. jal: T3 PCout Grb R_enable (link reg in rb field); T4 Gra Rout PC_enable.
- in: T3 InPort_enable; T4 InPortout Gra R_enable. out: T3 Gra Rout OutPort_enable. mfhi/mflo: T3 HIout/LOout Gra R_enable. nop: T3 no strobes.
- After the last step, go to T0. halt at T3 → HALT. `stop`=1 on the T0-entry edge → HALT instead of T0.
- HALT: all strobes 0, run=0; exit only via `clr`.

## Timing
- `clr` low: state→RST immediately. Every output is 0, including run. This applies mid-instruction; no partial write or RAM_write completes after assertion.
- First rising edge with `clr` high: RST→T0, run=1.
- One step per clock; there are no wait states.
- Instruction length in cycles, including fetch:
  - 4: jr, out, mfhi, mflo, nop
  - 5: neg, not, jal, in
  - 6: ALU 3-reg, immediate, ldi
  - 7: mul, div, br
  - 8: ld, st
- At most one bus driver is active per cycle (checked by assertion).

## Test plan
- Reset: hold `clr`=0 3 cycles → all outputs 0. Release → next edge T0: PCout=MAR_enable=IncPC=Z_enable=1, run=1.
- add (00011): T3 Grb+Rout+Y_enable; T4 Grc+Rout+Z_enable; T5 ZLowout+Gra+R_enable; cycle 7 is T0 again.
- ld (00000) then st (00010): MDR_read=010 at ld T6, RAM_write=1 only at st T7, each 8 cycles.
- br (10010): `CON_out`=1 → PC_enable=1 at T6; `CON_out`=0 → PC_enable=0 at T6. Both return to T0 at cycle 8.
- halt (11010): run drops after T3 and all strobes stay 0 for 20 cycles. `stop`=1 during an add → add completes, then HALT.
- Drop `clr` during mul T5 → outputs 0 asynchronously, no HI_enable pulse. Release → refetch from T0.
